beeb_ext_bus_bridge: RTL and testbench

- Parametrised external-bus engine between the fast internal CPU domain and the 2MHz host bus.
- Synchronises PhiIn and aligns host cycles to it.
- Adds a posted-write buffer, so screen and other external writes no longer stall the core.
- Generalises the addressable-latch slowdown into parameters. Sits between the CPU/decode logic and the host Addr/Data/R_W_n pins in the accelerator top level.

---
 rtl/beeb_accel_pkg.sv | 19 +
 rtl/beeb_wbuf.sv | 56 +++++
 rtl/beeb_ext_bus_bridge.sv | 167 ++++++++++++++++
 tb/tb_beeb_ext_bus_bridge.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/beeb_accel_pkg.sv
// Shared types and constants for the accelerator's external-bus logic.
package beeb_accel_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_DRAIN  = 2'd2
    } bus_state_e;

    localparam logic [15:0] BUS_IDLE_ADDR = 16'hFFFF;
    localparam logic [7:0]  BUS_IDLE_DATA = 8'hFF;

    // Addressable-latch style registers on the host I/O page
    localparam logic [15:0] LATCH_FE30 = 16'hFE30;
    localparam logic [15:0] LATCH_FE34 = 16'hFE34;
    localparam logic [15:0] LATCH_FE38 = 16'hFE38;
    localparam logic [15:0] LATCH_FE40 = 16'hFE40;

endpackage

// File: rtl/beeb_wbuf.sv
// Posted-write FIFO: synchronous, first-word-fall-through head, flushed by reset.
module beeb_wbuf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic                     clock,
    input  logic                     Res_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (level_q == LW'(0));
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A push into a full buffer is accepted only when a pop frees the slot in the same clock
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clock) begin
        if (!Res_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/beeb_ext_bus_bridge.sv
// External 2MHz host-bus engine: PhiIn alignment, posted writes, direct cycles and latch slowdown.
module beeb_ext_bus_bridge
    import beeb_accel_pkg::*;
#(
    parameter int unsigned       NPHI0_REGS = 5,
    parameter int unsigned       PHIOUT_TAP = 1,
    parameter int unsigned       ADDR_W     = 16,
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       WBUF_DEPTH = 4,
    parameter logic [ADDR_W-1:0] SLOW_ADDR  = ADDR_W'(LATCH_FE40),
    parameter int unsigned       SLOW_LONG  = 15,
    parameter int unsigned       SLOW_SHORT = 1
) (
    input  logic                          clock,
    input  logic                          Res_n,
    input  logic                          phi_in,
    input  logic                          req_valid,
    input  logic                          req_we,
    input  logic                          req_posted,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    output logic                          req_done,
    output logic [DATA_W-1:0]             rd_data,
    input  logic [DATA_W-1:0]             ext_data_in,
    output logic [ADDR_W-1:0]             beeb_AB,
    output logic                          beeb_WE,
    output logic [DATA_W-1:0]             beeb_DO,
    output logic                          phi_out,
    output logic                          ext_cycle_end,
    output logic                          slowdown_active,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_level,
    output logic                          wbuf_full
);

    localparam int unsigned N        = NPHI0_REGS;
    localparam int unsigned ENT_W    = ADDR_W + DATA_W;
    localparam int unsigned SLOW_MAX = (SLOW_LONG > SLOW_SHORT) ? SLOW_LONG : SLOW_SHORT;
    localparam int unsigned SLOW_W   = $clog2(SLOW_MAX + 1);
    localparam logic [ADDR_W-1:0] IDLE_AB = ADDR_W'(BUS_IDLE_ADDR);
    localparam logic [DATA_W-1:0] IDLE_DO = DATA_W'(BUS_IDLE_DATA);

    logic [N-1:0]      phi_q;
    logic [N-1:0]      phi_d;
    logic              cyc_start_q;
    logic [DATA_W-1:0] sample_q;
    bus_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ab_q, ab_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] do_q, do_d;
    logic              req_done_q, req_done_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [SLOW_W-1:0] slow_q, slow_d;

    logic              read_fall;
    logic              pending;
    logic              postable;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;
    logic              wb_full;
    logic              wb_empty;

    assign phi_d         = {phi_q[N-2:0], phi_in};
    assign ext_cycle_end = phi_q[N-1] & ~phi_q[N-2];
    assign read_fall     = phi_q[PHIOUT_TAP] & ~phi_d[PHIOUT_TAP];
    assign phi_out       = phi_q[PHIOUT_TAP];

    // The request is still held high during its own req_done clock, so it must not count again
    assign pending  = req_valid & ~req_done_q;
    assign postable = req_we & req_posted & (req_addr != SLOW_ADDR) & (slow_q == SLOW_W'(0));
    assign push     = pending & postable & (~wb_full | pop);
    assign pop      = ext_cycle_end & (state_q == S_DRAIN);

    beeb_wbuf #(
        .DEPTH (WBUF_DEPTH),
        .WIDTH (ENT_W)
    ) u_wbuf (
        .clock   (clock),
        .Res_n   (Res_n),
        .push_i  (push),
        .din_i   ({req_addr, req_wdata}),
        .pop_i   (pop),
        .dout_o  (head),
        .level_o (wbuf_level),
        .full_o  (wb_full),
        .empty_o (wb_empty)
    );

    // Cycle completion at ext_cycle_end, then bus ownership chosen at ext_cycle_start
    always_comb begin
        state_d    = state_q;
        ab_d       = ab_q;
        we_d       = we_q;
        do_d       = do_q;
        req_done_d = 1'b0;
        rd_data_d  = rd_data_q;
        slow_d     = slow_q;

        if (ext_cycle_end) begin
            if (state_q == S_DIRECT) begin
                req_done_d = 1'b1;
                if (!we_q) rd_data_d = sample_q;
            end
            if (we_q && (ab_q == SLOW_ADDR)) begin
                slow_d = (do_q[2:0] == 3'd0) ? SLOW_W'(SLOW_LONG) : SLOW_W'(SLOW_SHORT);
            end else if (slow_q != SLOW_W'(0)) begin
                slow_d = slow_q - SLOW_W'(1);
            end
        end

        if (cyc_start_q) begin
            if (!wb_empty) begin
                state_d = S_DRAIN;
                ab_d    = head[ENT_W-1:DATA_W];
                we_d    = 1'b1;
                do_d    = head[DATA_W-1:0];
            end else if (pending && !postable) begin
                state_d = S_DIRECT;
                ab_d    = req_addr;
                we_d    = req_we;
                do_d    = req_wdata;
            end else begin
                state_d = S_IDLE;
                ab_d    = IDLE_AB;
                we_d    = 1'b0;
                do_d    = IDLE_DO;
            end
        end

        if (push) req_done_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!Res_n) begin
            phi_q       <= '0;
            cyc_start_q <= 1'b0;
            sample_q    <= '0;
            state_q     <= S_IDLE;
            ab_q        <= IDLE_AB;
            we_q        <= 1'b0;
            do_q        <= IDLE_DO;
            req_done_q  <= 1'b0;
            rd_data_q   <= '0;
            slow_q      <= '0;
        end else begin
            phi_q       <= phi_d;
            cyc_start_q <= ext_cycle_end;
            if (read_fall) sample_q <= ext_data_in;
            state_q     <= state_d;
            ab_q        <= ab_d;
            we_q        <= we_d;
            do_q        <= do_d;
            req_done_q  <= req_done_d;
            rd_data_q   <= rd_data_d;
            slow_q      <= slow_d;
        end
    end

    assign beeb_AB         = ab_q;
    assign beeb_WE         = we_q;
    assign beeb_DO         = do_q;
    assign req_done        = req_done_q;
    assign rd_data         = rd_data_q;
    assign slowdown_active = (slow_q != SLOW_W'(0));
    assign wbuf_full       = wb_full;

endmodule

// File: tb/tb_beeb_ext_bus_bridge.sv
// Directed self-checking bench for beeb_ext_bus_bridge with a host-cycle scoreboard.
module tb_beeb_ext_bus_bridge;

    logic        clock = 1'b0;
    logic        Res_n = 1'b0;
    logic        phi_in = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic        req_posted = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [7:0]  req_wdata = 8'h0;
    logic [7:0]  ext_data_in = 8'h0;
    logic        req_done;
    logic [7:0]  rd_data;
    logic [15:0] beeb_AB;
    logic        beeb_WE;
    logic [7:0]  beeb_DO;
    logic        phi_out;
    logic        ext_cycle_end;
    logic        slowdown_active;
    logic [2:0]  wbuf_level;
    logic        wbuf_full;

    int n_checks = 0;
    int n_err    = 0;

    logic [24:0] mon_q [$];
    logic [24:0] exp_q [$];

    typedef struct {
        logic        we;
        logic        posted;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  ext;
        logic        fast;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs [6];

    beeb_ext_bus_bridge #(
        .NPHI0_REGS (5),
        .PHIOUT_TAP (1),
        .ADDR_W     (16),
        .DATA_W     (8),
        .WBUF_DEPTH (4),
        .SLOW_ADDR  (16'hFE40),
        .SLOW_LONG  (15),
        .SLOW_SHORT (1)
    ) dut (
        .clock           (clock),
        .Res_n           (Res_n),
        .phi_in          (phi_in),
        .req_valid       (req_valid),
        .req_we          (req_we),
        .req_posted      (req_posted),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_done        (req_done),
        .rd_data         (rd_data),
        .ext_data_in     (ext_data_in),
        .beeb_AB         (beeb_AB),
        .beeb_WE         (beeb_WE),
        .beeb_DO         (beeb_DO),
        .phi_out         (phi_out),
        .ext_cycle_end   (ext_cycle_end),
        .slowdown_active (slowdown_active),
        .wbuf_level      (wbuf_level),
        .wbuf_full       (wbuf_full)
    );

    always #5 clock = ~clock;
    always #40 phi_in = ~phi_in;

    // Log every non-idle host cycle as it completes
    always @(negedge clock) begin
        if (Res_n && ext_cycle_end && !(beeb_AB == 16'hFFFF && !beeb_WE))
            mon_q.push_back({beeb_AB, beeb_WE, beeb_DO});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic posted, input logic [15:0] addr,
                          input logic [7:0] wd, output int lat, output logic [7:0] rd,
                          output logic [2:0] lvl);
        logic ok;
        ok = 1'b0;
        lat = 0;
        req_we = we;
        req_posted = posted;
        req_addr = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        while (lat < 300 && !ok) begin
            tick();
            lat++;
            if (req_done) ok = 1'b1;
        end
        rd = rd_data;
        lvl = wbuf_level;
        req_valid = 1'b0;
        if (!ok) check("req_timeout", 32'(ok), 32'd1);
        tick();
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!ext_cycle_end && n < 50) begin
            tick();
            n++;
        end
        if (!ext_cycle_end) check("wait_end_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (wbuf_level != 3'd0 && n < 300) begin
            tick();
            n++;
        end
        if (wbuf_level != 3'd0) check("wait_empty_timeout", 32'(wbuf_level), 32'd0);
    endtask

    task automatic compare_bus(input string tag);
        logic [24:0] e;
        logic [24:0] got;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = (mon_q.size() > 0) ? mon_q.pop_front() : 25'h0;
            check(tag, 32'(got), 32'(e));
        end
        check({tag, "_extra"}, 32'(mon_q.size()), 32'd0);
        mon_q.delete();
    endtask

    task automatic count_slow_ends(output int cnt);
        int n;
        cnt = 0;
        n = 0;
        while (slowdown_active && n < 400) begin
            tick();
            n++;
            if (ext_cycle_end && slowdown_active) cnt++;
        end
    endtask

    initial begin
        int          lat;
        int          cnt;
        int          done_seen;
        logic [7:0]  rd;
        logic [2:0]  lvl;

        vecs[0] = '{we: 1'b0, posted: 1'b0, addr: 16'hFE4D, wdata: 8'h00, ext: 8'h5A, fast: 1'b0, exp_rd: 8'h5A};
        vecs[1] = '{we: 1'b1, posted: 1'b0, addr: 16'h1234, wdata: 8'h77, ext: 8'h00, fast: 1'b0, exp_rd: 8'h5A};
        vecs[2] = '{we: 1'b1, posted: 1'b1, addr: 16'h2000, wdata: 8'hA5, ext: 8'h00, fast: 1'b1, exp_rd: 8'h5A};
        vecs[3] = '{we: 1'b0, posted: 1'b0, addr: 16'h2000, wdata: 8'h00, ext: 8'hC3, fast: 1'b0, exp_rd: 8'hC3};
        vecs[4] = '{we: 1'b1, posted: 1'b1, addr: 16'h4000, wdata: 8'hAA, ext: 8'h00, fast: 1'b1, exp_rd: 8'hC3};
        vecs[5] = '{we: 1'b0, posted: 1'b0, addr: 16'h4000, wdata: 8'h00, ext: 8'h3C, fast: 1'b0, exp_rd: 8'h3C};

        // Reset state
        repeat (3) tick();
        check("rst_ab", 32'(beeb_AB), 32'hFFFF);
        check("rst_we", 32'(beeb_WE), 32'd0);
        check("rst_do", 32'(beeb_DO), 32'hFF);
        check("rst_done", 32'(req_done), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        check("rst_level", 32'(wbuf_level), 32'd0);
        check("rst_full", 32'(wbuf_full), 32'd0);
        check("rst_slow", 32'(slowdown_active), 32'd0);
        check("rst_phi_out", 32'(phi_out), 32'd0);
        Res_n = 1'b1;
        tick();

        // Table of single transactions, including write-then-read ordering
        for (int i = 0; i < 6; i++) begin
            ext_data_in = vecs[i].ext;
            do_req(vecs[i].we, vecs[i].posted, vecs[i].addr, vecs[i].wdata, lat, rd, lvl);
            check($sformatf("vec%0d_rd", i), 32'(rd), 32'(vecs[i].exp_rd));
            if (vecs[i].fast) check($sformatf("vec%0d_posted_lat", i), 32'(lat), 32'd1);
            else              check($sformatf("vec%0d_direct_lat", i), 32'(lat > 1), 32'd1);
            if (!vecs[i].we)  check($sformatf("vec%0d_rd_after_drain", i), 32'(lvl), 32'd0);
            exp_q.push_back({vecs[i].addr, vecs[i].we, vecs[i].wdata});
        end
        wait_empty();
        tick();
        check("idle_ab", 32'(beeb_AB), 32'hFFFF);
        check("idle_we", 32'(beeb_WE), 32'd0);
        check("idle_do", 32'(beeb_DO), 32'hFF);
        compare_bus("vec_bus");

        // Posted burst of six into a four-entry buffer
        wait_end();
        for (int i = 0; i < 6; i++) begin
            do_req(1'b1, 1'b1, 16'h3000 + 16'(i), 8'(i + 1), lat, rd, lvl);
            exp_q.push_back({16'h3000 + 16'(i), 1'b1, 8'(i + 1)});
            if (i < 4) check($sformatf("burst%0d_lat", i), 32'(lat), 32'd1);
            if (i == 3) check("burst_full", 32'(lvl == 3'd4), 32'd1);
            if (i == 4) check("burst_push_pop_level", 32'(lvl), 32'd4);
            if (i == 5) check("burst_wait_slot", 32'(lat > 1), 32'd1);
        end
        check("rd_hold", 32'(rd_data), 32'h3C);
        wait_empty();
        tick();
        compare_bus("burst_bus");

        // Long slowdown: exactly 15 host cycles
        do_req(1'b1, 1'b1, 16'hFE40, 8'h00, lat, rd, lvl);
        exp_q.push_back({16'hFE40, 1'b1, 8'h00});
        check("slow_unposted_lat", 32'(lat > 1), 32'd1);
        check("slow_active", 32'(slowdown_active), 32'd1);
        count_slow_ends(cnt);
        check("slow_long_count", 32'(cnt), 32'd15);

        // Posted write during slowdown becomes a direct host cycle
        do_req(1'b1, 1'b1, 16'hFE40, 8'h00, lat, rd, lvl);
        exp_q.push_back({16'hFE40, 1'b1, 8'h00});
        do_req(1'b1, 1'b1, 16'h6000, 8'h55, lat, rd, lvl);
        exp_q.push_back({16'h6000, 1'b1, 8'h55});
        check("slow_posted_lat", 32'(lat > 2), 32'd1);
        check("slow_posted_level", 32'(lvl), 32'd0);
        count_slow_ends(cnt);

        // Short slowdown
        do_req(1'b1, 1'b1, 16'hFE40, 8'h09, lat, rd, lvl);
        exp_q.push_back({16'hFE40, 1'b1, 8'h09});
        count_slow_ends(cnt);
        check("slow_short_count", 32'(cnt), 32'd1);
        do_req(1'b1, 1'b1, 16'h6100, 8'h66, lat, rd, lvl);
        exp_q.push_back({16'h6100, 1'b1, 8'h66});
        check("post_after_slow_lat", 32'(lat), 32'd1);
        wait_empty();
        tick();
        compare_bus("slow_bus");

        // Reset in the middle of a drain cycle with three entries queued
        wait_end();
        for (int i = 0; i < 3; i++) do_req(1'b1, 1'b1, 16'h7000 + 16'(i), 8'(8'hE0 + i), lat, rd, lvl);
        check("pre_rst_level", 32'(wbuf_level), 32'd3);
        check("pre_rst_drain_we", 32'(beeb_WE), 32'd1);
        Res_n = 1'b0;
        tick();
        check("mid_rst_ab", 32'(beeb_AB), 32'hFFFF);
        check("mid_rst_we", 32'(beeb_WE), 32'd0);
        check("mid_rst_do", 32'(beeb_DO), 32'hFF);
        check("mid_rst_level", 32'(wbuf_level), 32'd0);
        check("mid_rst_done", 32'(req_done), 32'd0);
        check("mid_rst_slow", 32'(slowdown_active), 32'd0);
        Res_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (req_done) done_seen++;
        end
        check("post_rst_no_done", 32'(done_seen), 32'd0);
        check("post_rst_level", 32'(wbuf_level), 32'd0);
        compare_bus("rst_bus");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
